// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame sequencer.
//   state_t            : FSM encoding (HUNT/PAYLOAD/CHECK/COMMIT)
//   PAYLOAD_LEN        : bytes captured after the sync byte
//   IDX_LINT..IDX_MODE : shadow register slot for each payload byte
//   DEFAULT_SYNC_BYTE  : frame start marker
package rgbw_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam int PAYLOAD_LEN = 7;

  localparam int IDX_LINT  = 0;
  localparam int IDX_COLOR = 1;
  localparam int IDX_RED   = 2;
  localparam int IDX_GREEN = 3;
  localparam int IDX_BLUE  = 4;
  localparam int IDX_WHITE = 5;
  localparam int IDX_MODE  = 6;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

endpackage

// File: rtl/rgbw_rdy_edge_sync.sv
// Brings the SPI byte-ready level into the clk domain and turns its rising
// edge into a strobe.
//   clk    : system clock
//   reset  : synchronous, active-low
//   ce     : clock enable; flops advance only when high
//   rx_rdy : byte-ready level, asynchronous to clk
//   strobe : s2 & ~s3, high for one ce period per rising edge of rx_rdy
module rgbw_rdy_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic rx_rdy,
  output logic strobe
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (ce) begin
      s1 <= rx_rdy;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe = s2 & ~s3;

endmodule

// File: rtl/rgbw_frame_sequencer.sv
// Frame sequencer for the RGBW SPI register path. Hunts for SYNC_BYTE,
// captures a 7-byte payload into shadows and commits all outputs on a single
// edge so the colour generator never sees a mix of two frames. A stalled
// frame is aborted after TIMEOUT_CYCLES strobe-less ce cycles.
// Optional build macro: RGBW_FRAME_CHECKSUM_EN adds a trailing XOR byte
// that must match before the commit.
//   clk, reset (sync, active-low), ce (half-rate tick)
//   rx_byte, rx_rdy      : SPI receiver byte and ready level
//   lint..mode           : committed frame fields
//   frame_ok / frame_err : one-ce-period pulses (commit / abort)
//   busy                 : state is not HUNT
//
// state   | meaning
// HUNT    | discard bytes until SYNC_BYTE
// PAYLOAD | store bytes into shadow[idx], inter-byte timeout running
// CHECK   | wait for checksum byte (checksum build only)
// COMMIT  | load outputs from shadows, pulse frame_ok, act as HUNT for strobes
module rgbw_frame_sequencer
  import rgbw_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  output logic [7:0] lint,
  output logic [7:0] color_idx,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] mode,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST = 3'(PAYLOAD_LEN - 1);

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [7:0]      shadow [PAYLOAD_LEN];
  logic            strobe, store, load, frame_ok_n, frame_err_n, to_hit;

  rgbw_rdy_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .rx_rdy (rx_rdy),
    .strobe (strobe)
  );

  // Abort on the TIMEOUT_CYCLES-th consecutive ce cycle without a strobe.
  assign to_hit = (to_cnt == TO_LAST);
  assign busy   = (state != HUNT);

`ifdef RGBW_FRAME_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++) csum = csum ^ shadow[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HUNT;
      idx       <= '0;
      to_cnt    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      lint      <= '0;
      color_idx <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      white     <= '0;
      mode      <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
    end else if (ce) begin
      state     <= state_n;
      idx       <= idx_n;
      to_cnt    <= to_cnt_n;
      frame_ok  <= frame_ok_n;
      frame_err <= frame_err_n;
      if (store) shadow[idx] <= rx_byte;
      if (load) begin
        lint      <= shadow[IDX_LINT];
        color_idx <= shadow[IDX_COLOR];
        red       <= shadow[IDX_RED];
        green     <= shadow[IDX_GREEN];
        blue      <= shadow[IDX_BLUE];
        white     <= shadow[IDX_WHITE];
        mode      <= shadow[IDX_MODE];
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    to_cnt_n    = to_cnt;
    store       = 1'b0;
    load        = 1'b0;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      HUNT, COMMIT: begin
        // COMMIT lasts one ce cycle; a strobe landing here is treated as in HUNT.
        load       = (state == COMMIT);
        frame_ok_n = (state == COMMIT);
        state_n    = HUNT;
        if (strobe && (rx_byte == SYNC_BYTE)) begin
          state_n  = PAYLOAD;
          idx_n    = '0;
          to_cnt_n = '0;
        end
      end
      PAYLOAD: begin
        // Strobe takes priority over a coincident timeout.
        if (strobe) begin
          store    = 1'b1;
          idx_n    = idx + 3'd1;
          to_cnt_n = '0;
          if (idx == IDX_LAST) begin
`ifdef RGBW_FRAME_CHECKSUM_EN
            state_n = CHECK;
`else
            state_n = COMMIT;
`endif
          end
        end else if (to_hit) begin
          frame_err_n = 1'b1;
          state_n     = HUNT;
          to_cnt_n    = '0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
`ifdef RGBW_FRAME_CHECKSUM_EN
      CHECK: begin
        if (strobe) begin
          to_cnt_n = '0;
          if (rx_byte == csum) begin
            state_n = COMMIT;
          end else begin
            frame_err_n = 1'b1;
            state_n     = HUNT;
          end
        end else if (to_hit) begin
          frame_err_n = 1'b1;
          state_n     = HUNT;
          to_cnt_n    = '0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
`endif
      default: state_n = HUNT;
    endcase
  end

endmodule

// File: tb/tb_rgbw_frame_sequencer.sv
// Bench for rgbw_frame_sequencer: table of frames with hand-written expected
// outputs, plus directed timeout, reset and (checksum build) bad-XOR cases.
// A background monitor checks that outputs only change together with a fresh
// frame_ok, that pulses last exactly one ce period and never overlap.
module tb_rgbw_frame_sequencer;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] lint, color_idx, red, green, blue, white, mode;
  logic       frame_ok, frame_err, busy;

  int total = 0;
  int bad = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int ok_run = 0;
  int err_run = 0;
  logic [55:0] prev_out;

  rgbw_frame_sequencer #(
    .SYNC_BYTE      (8'h55),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .rx_byte   (rx_byte),
    .rx_rdy    (rx_rdy),
    .lint      (lint),
    .color_idx (color_idx),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .mode      (mode),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      ce = ~ce;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] pre;
    int          npre;
    logic [55:0] payload;
    logic [7:0]  e_lint, e_cidx, e_red, e_green, e_blue, e_white, e_mode;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        if ({lint, color_idx, red, green, blue, white, mode} !== prev_out) begin
          total++;
          if (!frame_ok || ok_run != 0) begin
            bad++;
            $display("FAIL out_atomic: outputs became %h without fresh frame_ok (ok=%b)",
                     {lint, color_idx, red, green, blue, white, mode}, frame_ok);
          end
        end
        if (frame_ok && frame_err) begin
          total++;
          bad++;
          $display("FAIL pulse_overlap: frame_ok=%b frame_err=%b required not both", frame_ok, frame_err);
        end
        if (frame_ok) begin
          if (ok_run == 0) ok_cnt++;
          ok_run++;
        end else begin
          if (ok_run != 0) chk("ok_width_clks", ok_run, 2);
          ok_run = 0;
        end
        if (frame_err) begin
          if (err_run == 0) err_cnt++;
          err_run++;
        end else begin
          if (err_run != 0) chk("err_width_clks", err_run, 2);
          err_run = 0;
        end
      end else begin
        ok_run  = 0;
        err_run = 0;
      end
      prev_out = {lint, color_idx, red, green, blue, white, mode};
    end
  endtask

  // rx_rdy high for 8 clk (4 ce edges; strobe lands on the 3rd), then low for 8.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    repeat (8) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (8) @(negedge clk);
  endtask

`ifdef RGBW_FRAME_CHECKSUM_EN
  function automatic logic [7:0] xsum(input logic [55:0] p);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ p[55-8*i -: 8];
    return x;
  endfunction
`endif

  task automatic send_frame(input logic [55:0] p);
    send_byte(8'h55);
    for (int i = 0; i < 7; i++) send_byte(p[55-8*i -: 8]);
`ifdef RGBW_FRAME_CHECKSUM_EN
    send_byte(xsum(p));
`endif
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, "_lint"},  lint,      v.e_lint);
    chk({tag, "_cidx"},  color_idx, v.e_cidx);
    chk({tag, "_red"},   red,       v.e_red);
    chk({tag, "_green"}, green,     v.e_green);
    chk({tag, "_blue"},  blue,      v.e_blue);
    chk({tag, "_white"}, white,     v.e_white);
    chk({tag, "_mode"},  mode,      v.e_mode);
  endtask

  initial begin
    int ok0, err0, n;
    vec_t zero;

    vecs[0] = '{pre: 24'h0,      npre: 0, payload: 56'h80031020304002,
                e_lint: 8'h80, e_cidx: 8'h03, e_red: 8'h10, e_green: 8'h20,
                e_blue: 8'h30, e_white: 8'h40, e_mode: 8'h02};
    vecs[1] = '{pre: 24'hAA1200, npre: 2, payload: 56'h11223344667788,
                e_lint: 8'h11, e_cidx: 8'h22, e_red: 8'h33, e_green: 8'h44,
                e_blue: 8'h66, e_white: 8'h77, e_mode: 8'h88};
    vecs[2] = '{pre: 24'h0,      npre: 0, payload: 56'h55550102030405,
                e_lint: 8'h55, e_cidx: 8'h55, e_red: 8'h01, e_green: 8'h02,
                e_blue: 8'h03, e_white: 8'h04, e_mode: 8'h05};
    vecs[3] = '{pre: 24'h0,      npre: 0, payload: 56'hFF00FF00FF00A5,
                e_lint: 8'hFF, e_cidx: 8'h00, e_red: 8'hFF, e_green: 8'h00,
                e_blue: 8'hFF, e_white: 8'h00, e_mode: 8'hA5};
    zero = '{pre: 24'h0, npre: 0, payload: 56'h0, e_lint: 8'h0, e_cidx: 8'h0,
             e_red: 8'h0, e_green: 8'h0, e_blue: 8'h0, e_white: 8'h0, e_mode: 8'h0};

    fork
      monitor();
    join_none

    // Reset with ce toggling
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_outs("rst", zero);
    chk("rst_busy", busy, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      ok0  = ok_cnt;
      err0 = err_cnt;
      for (int j = 0; j < vecs[v].npre; j++) send_byte(vecs[v].pre[23-8*j -: 8]);
      send_frame(vecs[v].payload);
      repeat (4) @(negedge clk);
      chk_outs($sformatf("vec%0d", v), vecs[v]);
      chk($sformatf("vec%0d_okpulses", v), ok_cnt - ok0, 1);
      chk($sformatf("vec%0d_errpulses", v), err_cnt - err0, 0);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Timeout mid-payload: outputs keep previous frame
    ok0  = ok_cnt;
    err0 = err_cnt;
    send_byte(8'h55);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("to_busy_before", busy, 1);
    chk("to_no_early_err", err_cnt - err0, 0);
    n = 0;
    while (err_cnt == err0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("to_errpulses", err_cnt - err0, 1);
    chk("to_latency_in_window", (n >= 20 && n <= 40), 1);
    repeat (4) @(negedge clk);
    chk_outs("to_hold", vecs[3]);
    chk("to_okpulses", ok_cnt - ok0, 0);
    chk("to_busy_after", busy, 0);
    ok0 = ok_cnt;
    send_frame(vecs[0].payload);
    repeat (4) @(negedge clk);
    chk_outs("to_recover", vecs[0]);
    chk("to_recover_ok", ok_cnt - ok0, 1);

`ifdef RGBW_FRAME_CHECKSUM_EN
    // Wrong checksum: error pulse, no commit
    ok0  = ok_cnt;
    err0 = err_cnt;
    send_byte(8'h55);
    for (int i = 0; i < 7; i++) send_byte(vecs[2].payload[55-8*i -: 8]);
    send_byte(xsum(vecs[2].payload) ^ 8'h01);
    repeat (4) @(negedge clk);
    chk("cs_bad_err", err_cnt - err0, 1);
    chk("cs_bad_ok", ok_cnt - ok0, 0);
    chk_outs("cs_bad_hold", vecs[0]);
    chk("cs_bad_busy", busy, 0);
`endif

    // Reset asserted mid-payload
    send_byte(8'h55);
    send_byte(8'h09);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk_outs("mid_rst", zero);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ok", frame_ok, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    ok0 = ok_cnt;
    send_frame(vecs[2].payload);
    repeat (4) @(negedge clk);
    chk_outs("post_rst", vecs[2]);
    chk("post_rst_ok", ok_cnt - ok0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
